// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types for the load/store memory controller: access sizes, FSM states,
// store lane steering and the misalignment rule.
package lsu_mem_ctrl_pkg;

   typedef logic [1:0] ls_size_t;
   localparam ls_size_t LS_BYTE = 2'd0;
   localparam ls_size_t LS_HALF = 2'd1;
   localparam ls_size_t LS_WORD = 2'd2;  // 2'd3 is reserved and behaves as a word

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } store_lanes_t;

   function automatic store_lanes_t store_lanes(input ls_size_t size,
                                                input logic [1:0] off,
                                                input logic [31:0] wdata);
      store_lanes_t l;
      case (size)
         LS_BYTE: begin
            l.wdata = {4{wdata[7:0]}};
            l.wstrb = 4'b0001 << off;
         end
         LS_HALF: begin
            l.wdata = {2{wdata[15:0]}};
            l.wstrb = 4'b0011 << {off[1], 1'b0};
         end
         default: begin
            l.wdata = wdata;
            l.wstrb = 4'b1111;
         end
      endcase
      return l;
   endfunction

   function automatic logic is_misaligned(input ls_size_t size, input logic [1:0] off);
      case (size)
         LS_BYTE: return 1'b0;
         LS_HALF: return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and extends it.
module lsu_load_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  ls_size_t    size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      data = shifted;
      case (size)
         LS_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         LS_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bus controller: issues one EX memory op, stalls the pipe until
// the response, writes back aligned load data. Optional LSU_MISALIGN_CHK_EN.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_ex_ls_valid,
   input  logic              I_ex_ls_load,
   input  logic [1:0]        I_ex_ls_size,
   input  logic              I_ex_ls_unsigned,
   input  logic [ADDR_W-1:0] I_ex_addr,
   input  logic [DATA_W-1:0] I_ex_wdata,
   input  logic [4:0]        I_ex_rd_waddr,
   input  logic              I_flush,
   output logic              O_mem_req,
   output logic              O_mem_we,
   output logic [ADDR_W-1:0] O_mem_addr,
   output logic [DATA_W-1:0] O_mem_wdata,
   output logic [3:0]        O_mem_wstrb,
   input  logic              I_mem_ready,
   input  logic              I_mem_rvalid,
   input  logic [DATA_W-1:0] I_mem_rdata,
   output logic              O_wb_we,
   output logic [4:0]        O_wb_waddr,
   output logic [DATA_W-1:0] O_wb_wdata,
   output logic              O_stallreq,
`ifdef LSU_MISALIGN_CHK_EN
   output logic              O_misalign,
`endif
   output lsu_state_e        O_dbg_state
);

   // Bus handshake: a request transfers on the cycle O_mem_req & I_mem_ready;
   // until then addr/we/wdata/wstrb stay stable. I_mem_rvalid is one response
   // per transfer, arriving at least one cycle after it and only honoured in WAIT.

   lsu_state_e        state, state_nxt;
   logic              misalign, accept;
   store_lanes_t      ex_lanes;
   logic [DATA_W-1:0] align_data;

   logic              r_load, r_uns, r_flushed;
   ls_size_t          r_size;
   logic [1:0]        r_off;
   logic [4:0]        r_rd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wstrb;

`ifdef LSU_MISALIGN_CHK_EN
   assign misalign   = is_misaligned(I_ex_ls_size, I_ex_addr[1:0]);
   assign O_misalign = ~I_rst & (state == LSU_IDLE) & I_ex_ls_valid & ~I_flush & misalign;
`else
   assign misalign = 1'b0;
`endif

   assign accept   = ~I_rst & (state == LSU_IDLE) & I_ex_ls_valid & ~I_flush & ~misalign;
   assign ex_lanes = store_lanes(I_ex_ls_size, I_ex_addr[1:0], I_ex_wdata);

   always_ff @(posedge I_clk) begin
      if (I_rst) state <= LSU_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE: if (accept) state_nxt = I_mem_ready ? LSU_WAIT : LSU_REQ;
         LSU_REQ: begin
            if (I_flush)          state_nxt = LSU_IDLE;
            else if (I_mem_ready) state_nxt = LSU_WAIT;
         end
         LSU_WAIT: if (I_mem_rvalid) state_nxt = LSU_IDLE;
         default: state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_load    <= 1'b0;
         r_uns     <= 1'b0;
         r_flushed <= 1'b0;
         r_size    <= LS_BYTE;
         r_off     <= 2'b00;
         r_rd      <= 5'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= 4'b0000;
      end else if (accept) begin
         r_load    <= I_ex_ls_load;
         r_uns     <= I_ex_ls_unsigned;
         r_flushed <= 1'b0;
         r_size    <= I_ex_ls_size;
         r_off     <= I_ex_addr[1:0];
         r_rd      <= I_ex_rd_waddr;
         r_addr    <= {I_ex_addr[ADDR_W-1:2], 2'b00};
         r_wdata   <= I_ex_ls_load ? '0 : ex_lanes.wdata;
         r_wstrb   <= I_ex_ls_load ? 4'b0000 : ex_lanes.wstrb;
      end else if (state == LSU_WAIT && I_flush) begin
         r_flushed <= 1'b1;
      end
   end

   // A flush in REQ withdraws the request in the same cycle so no transfer can slip through.
   always_comb begin
      O_mem_req   = 1'b0;
      O_mem_we    = 1'b0;
      O_mem_addr  = '0;
      O_mem_wdata = '0;
      O_mem_wstrb = 4'b0000;
      O_stallreq  = 1'b0;
      O_wb_we     = 1'b0;
      if (!I_rst) begin
         case (state)
            LSU_IDLE: begin
               if (accept) begin
                  O_mem_req   = 1'b1;
                  O_mem_we    = ~I_ex_ls_load;
                  O_mem_addr  = {I_ex_addr[ADDR_W-1:2], 2'b00};
                  O_mem_wdata = I_ex_ls_load ? '0 : ex_lanes.wdata;
                  O_mem_wstrb = I_ex_ls_load ? 4'b0000 : ex_lanes.wstrb;
                  O_stallreq  = 1'b1;
               end
            end
            LSU_REQ: begin
               O_stallreq = 1'b1;
               if (!I_flush) begin
                  O_mem_req   = 1'b1;
                  O_mem_we    = ~r_load;
                  O_mem_addr  = r_addr;
                  O_mem_wdata = r_wdata;
                  O_mem_wstrb = r_wstrb;
               end
            end
            LSU_WAIT: begin
               O_stallreq = 1'b1;
               O_wb_we    = I_mem_rvalid & r_load & ~r_flushed & ~I_flush;
            end
            default: ;
         endcase
      end
   end

   lsu_load_align u_load_align (
      .rdata       (I_mem_rdata),
      .offset      (r_off),
      .size        (r_size),
      .is_unsigned (r_uns),
      .data        (align_data)
   );

   assign O_wb_waddr  = O_wb_we ? r_rd : 5'd0;
   assign O_wb_wdata  = O_wb_we ? align_data : '0;
   assign O_dbg_state = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl; also covers LSU_MISALIGN_CHK_EN when defined.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_ex_ls_valid, I_ex_ls_load, I_ex_ls_unsigned, I_flush;
   logic [1:0]  I_ex_ls_size;
   logic [31:0] I_ex_addr, I_ex_wdata;
   logic [4:0]  I_ex_rd_waddr;
   logic        O_mem_req, O_mem_we, I_mem_ready, I_mem_rvalid;
   logic [31:0] O_mem_addr, O_mem_wdata, I_mem_rdata;
   logic [3:0]  O_mem_wstrb;
   logic        O_wb_we, O_stallreq;
   logic [4:0]  O_wb_waddr;
   logic [31:0] O_wb_wdata;
   lsu_state_e  O_dbg_state;
`ifdef LSU_MISALIGN_CHK_EN
   logic        O_misalign;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [36:0] exp_q[$];

   lsu_mem_ctrl dut (
      .I_clk(I_clk), .I_rst(I_rst),
      .I_ex_ls_valid(I_ex_ls_valid), .I_ex_ls_load(I_ex_ls_load),
      .I_ex_ls_size(I_ex_ls_size), .I_ex_ls_unsigned(I_ex_ls_unsigned),
      .I_ex_addr(I_ex_addr), .I_ex_wdata(I_ex_wdata), .I_ex_rd_waddr(I_ex_rd_waddr),
      .I_flush(I_flush),
      .O_mem_req(O_mem_req), .O_mem_we(O_mem_we), .O_mem_addr(O_mem_addr),
      .O_mem_wdata(O_mem_wdata), .O_mem_wstrb(O_mem_wstrb),
      .I_mem_ready(I_mem_ready), .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
      .O_wb_we(O_wb_we), .O_wb_waddr(O_wb_waddr), .O_wb_wdata(O_wb_wdata),
      .O_stallreq(O_stallreq),
`ifdef LSU_MISALIGN_CHK_EN
      .O_misalign(O_misalign),
`endif
      .O_dbg_state(O_dbg_state)
   );

   // clock / reset
   always #5 I_clk = ~I_clk;

   task automatic apply_reset();
      I_rst = 1'b1;
      repeat (3) @(posedge I_clk);
      #1 I_rst = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge I_clk);
   endtask

   task automatic issue(input logic load, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
      I_ex_ls_valid    = 1'b1;
      I_ex_ls_load     = load;
      I_ex_ls_size     = size;
      I_ex_ls_unsigned = uns;
      I_ex_addr        = addr;
      I_ex_wdata       = wdata;
      I_ex_rd_waddr    = rd;
   endtask

   task automatic clear_ex();
      I_ex_ls_valid = 1'b0;
      I_ex_addr     = 32'hFFFF_FFFF;
      I_ex_wdata    = 32'h5555_5555;
   endtask

   // Load accepted immediately, response one cycle after acceptance.
   task automatic load_op(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp);
      issue(1'b1, size, uns, addr, 32'h0, rd);
      I_mem_ready = 1'b1;
      exp_q.push_back({rd, exp});
      sample();
      check({tag, "_req"}, 32'(O_mem_req), 32'd1);
      check({tag, "_addr"}, O_mem_addr, {addr[31:2], 2'b00});
      tick();
      clear_ex();
      I_mem_ready  = 1'b0;
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = rdata;
      sample();
      check({tag, "_wbwe"}, 32'(O_wb_we), 32'd1);
      check({tag, "_wbdata"}, O_wb_wdata, exp);
      tick();
      I_mem_rvalid = 1'b0;
      sample();
      check({tag, "_stall_end"}, 32'(O_stallreq), 32'd0);
      tick();
   endtask

   // Store accepted immediately; bus fields checked, ack one cycle later.
   task automatic store_op(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      issue(1'b0, size, 1'b0, addr, wdata, 5'd0);
      I_mem_ready = 1'b1;
      sample();
      check({tag, "_we"}, 32'(O_mem_we), 32'd1);
      check({tag, "_addr"}, O_mem_addr, exp_addr);
      check({tag, "_strb"}, 32'(O_mem_wstrb), 32'(exp_strb));
      check({tag, "_wdata"}, O_mem_wdata, exp_wdata);
      tick();
      clear_ex();
      I_mem_ready  = 1'b0;
      I_mem_rvalid = 1'b1;
      sample();
      check({tag, "_nowb"}, 32'(O_wb_we), 32'd0);
      check({tag, "_stall"}, 32'(O_stallreq), 32'd1);
      tick();
      I_mem_rvalid = 1'b0;
      sample();
      check({tag, "_idle"}, 32'(O_dbg_state), 32'(LSU_IDLE));
      tick();
   endtask

   // scoreboard: every writeback must match the oldest expected {rd, data}
   always @(negedge I_clk) begin
      if (!I_rst && O_wb_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_wb", 32'd1, 32'd0);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("sb_waddr", 32'(O_wb_waddr), 32'(e[36:32]));
            check("sb_wdata", O_wb_wdata, e[31:0]);
         end
      end
   end

   initial begin
      I_ex_ls_valid = 0; I_ex_ls_load = 0; I_ex_ls_size = 0; I_ex_ls_unsigned = 0;
      I_ex_addr = 0; I_ex_wdata = 0; I_ex_rd_waddr = 0; I_flush = 0;
      I_mem_ready = 0; I_mem_rvalid = 0; I_mem_rdata = 0;
      apply_reset();

      // reset values (reset asserted again briefly with EX idle)
      I_rst = 1'b1;
      sample();
      check("rst_req", 32'(O_mem_req), 32'd0);
      check("rst_stall", 32'(O_stallreq), 32'd0);
      check("rst_wbwe", 32'(O_wb_we), 32'd0);
      tick();
      I_rst = 1'b0;
      sample();
      check("rst_state", 32'(O_dbg_state), 32'(LSU_IDLE));
      tick();

      // LW 0x1000, ready on entry, rvalid two cycles later: stall for 3 cycles
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_1000, 32'h0, 5'd5);
      I_mem_ready = 1'b1;
      exp_q.push_back({5'd5, 32'hDEAD_BEEF});
      sample();
      check("lw_req", 32'(O_mem_req), 32'd1);
      check("lw_we", 32'(O_mem_we), 32'd0);
      check("lw_addr", O_mem_addr, 32'h0000_1000);
      check("lw_stall0", 32'(O_stallreq), 32'd1);
      tick();
      clear_ex();
      I_mem_ready = 1'b0;
      sample();
      check("lw_state_wait", 32'(O_dbg_state), 32'(LSU_WAIT));
      check("lw_stall1", 32'(O_stallreq), 32'd1);
      check("lw_req_low", 32'(O_mem_req), 32'd0);
      tick();
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'hDEAD_BEEF;
      sample();
      check("lw_stall2", 32'(O_stallreq), 32'd1);
      check("lw_wbwe", 32'(O_wb_we), 32'd1);
      check("lw_waddr", 32'(O_wb_waddr), 32'd5);
      check("lw_wdata", O_wb_wdata, 32'hDEAD_BEEF);
      tick();
      I_mem_rvalid = 1'b0;
      sample();
      check("lw_stall3", 32'(O_stallreq), 32'd0);
      check("lw_wb_pulse", 32'(O_wb_we), 32'd0);
      tick();

      // load alignment / extension
      load_op("lb",  LS_BYTE, 1'b0, 32'h0000_1003, 5'd6, 32'h8012_3456, 32'hFFFF_FF80);
      load_op("lbu", LS_BYTE, 1'b1, 32'h0000_1003, 5'd7, 32'h8012_3456, 32'h0000_0080);
      load_op("lh",  LS_HALF, 1'b0, 32'h0000_1002, 5'd8, 32'h8001_1234, 32'hFFFF_8001);
      load_op("lhu", LS_HALF, 1'b1, 32'h0000_1000, 5'd9, 32'h1234_F00D, 32'h0000_F00D);
      load_op("lb1", LS_BYTE, 1'b0, 32'h0000_1001, 5'd10, 32'h1234_7F00, 32'h0000_007F);

      // store lane steering
      store_op("sb", LS_BYTE, 32'h0000_2001, 32'h0000_00A5, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5);
      store_op("sh", LS_HALF, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 4'b1100, 32'h1234_1234);
      store_op("sw", LS_WORD, 32'h0000_2004, 32'hCAFE_F00D, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);
      store_op("sr", 2'd3,    32'h0000_2008, 32'h0102_0304, 32'h0000_2008, 4'b1111, 32'h0102_0304);

      // ready held low for 4 cycles: request held stable
      issue(1'b0, LS_HALF, 1'b0, 32'h0000_4006, 32'h0000_BEEF, 5'd0);
      I_mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample();
         check("hold_req", 32'(O_mem_req), 32'd1);
         check("hold_addr", O_mem_addr, 32'h0000_4004);
         check("hold_strb", 32'(O_mem_wstrb), 32'hC);
         check("hold_wdata", O_mem_wdata, 32'hBEEF_BEEF);
         check("hold_stall", 32'(O_stallreq), 32'd1);
         tick();
         clear_ex();
      end
      I_mem_ready = 1'b1;
      sample();
      check("hold_hs_req", 32'(O_mem_req), 32'd1);
      tick();
      I_mem_ready  = 1'b0;
      I_mem_rvalid = 1'b1;
      sample();
      check("hold_ack_state", 32'(O_dbg_state), 32'(LSU_WAIT));
      tick();
      I_mem_rvalid = 1'b0;
      sample();
      check("hold_done", 32'(O_stallreq), 32'd0);
      tick();

      // flush in IDLE: op never starts
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_5000, 32'h0, 5'd11);
      I_flush = 1'b1;
      sample();
      check("fidle_req", 32'(O_mem_req), 32'd0);
      check("fidle_stall", 32'(O_stallreq), 32'd0);
      tick();
      clear_ex();
      I_flush = 1'b0;
      sample();
      check("fidle_state", 32'(O_dbg_state), 32'(LSU_IDLE));
      tick();

      // flush in REQ: request dropped, no transfer
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_5000, 32'h0, 5'd12);
      sample();
      check("freq_req0", 32'(O_mem_req), 32'd1);
      tick();
      clear_ex();
      I_flush = 1'b1;
      sample();
      check("freq_state", 32'(O_dbg_state), 32'(LSU_REQ));
      tick();
      I_flush     = 1'b0;
      I_mem_ready = 1'b1;
      sample();
      check("freq_req_drop", 32'(O_mem_req), 32'd0);
      check("freq_idle", 32'(O_dbg_state), 32'(LSU_IDLE));
      check("freq_stall", 32'(O_stallreq), 32'd0);
      tick();
      I_mem_ready = 1'b0;

      // flush in WAIT: response consumed, writeback suppressed
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_5004, 32'h0, 5'd13);
      I_mem_ready = 1'b1;
      sample();
      tick();
      clear_ex();
      I_mem_ready = 1'b0;
      I_flush     = 1'b1;
      sample();
      check("fwait_stall0", 32'(O_stallreq), 32'd1);
      tick();
      I_flush = 1'b0;
      sample();
      check("fwait_stall1", 32'(O_stallreq), 32'd1);
      check("fwait_state", 32'(O_dbg_state), 32'(LSU_WAIT));
      tick();
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'h1111_2222;
      sample();
      check("fwait_nowb", 32'(O_wb_we), 32'd0);
      check("fwait_stall2", 32'(O_stallreq), 32'd1);
      tick();
      I_mem_rvalid = 1'b0;
      sample();
      check("fwait_idle", 32'(O_stallreq), 32'd0);
      tick();

      // back-to-back loads: second issues the cycle after the first rvalid
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_6000, 32'h0, 5'd14);
      I_mem_ready = 1'b1;
      exp_q.push_back({5'd14, 32'h0A0B_0C0D});
      sample();
      tick();
      I_mem_ready  = 1'b0;
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'h0A0B_0C0D;
      sample();
      check("b2b_wb1", 32'(O_wb_we), 32'd1);
      tick();
      I_mem_rvalid = 1'b0;
      issue(1'b1, LS_BYTE, 1'b1, 32'h0000_6002, 32'h0, 5'd15);
      I_mem_ready = 1'b1;
      exp_q.push_back({5'd15, 32'h0000_00C3});
      sample();
      check("b2b_req2", 32'(O_mem_req), 32'd1);
      check("b2b_addr2", O_mem_addr, 32'h0000_6000);
      tick();
      clear_ex();
      I_mem_ready  = 1'b0;
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'h11C3_2233;
      sample();
      check("b2b_wb2", O_wb_wdata, 32'h0000_00C3);
      tick();
      I_mem_rvalid = 1'b0;

      // stray rvalid in IDLE is ignored
      I_mem_rvalid = 1'b1;
      sample();
      check("stray_wb", 32'(O_wb_we), 32'd0);
      check("stray_state", 32'(O_dbg_state), 32'(LSU_IDLE));
      tick();
      I_mem_rvalid = 1'b0;

      // reset mid-transfer
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_7000, 32'h0, 5'd16);
      I_mem_ready = 1'b1;
      sample();
      tick();
      clear_ex();
      I_mem_ready = 1'b0;
      I_rst = 1'b1;
      sample();
      check("rstx_stall", 32'(O_stallreq), 32'd0);
      tick();
      I_rst        = 1'b0;
      I_mem_rvalid = 1'b1;
      sample();
      check("rstx_state", 32'(O_dbg_state), 32'(LSU_IDLE));
      check("rstx_nowb", 32'(O_wb_we), 32'd0);
      tick();
      I_mem_rvalid = 1'b0;

`ifdef LSU_MISALIGN_CHK_EN
      // misaligned word: reported, not issued
      issue(1'b1, LS_WORD, 1'b0, 32'h0000_3002, 32'h0, 5'd17);
      sample();
      check("mis_pulse", 32'(O_misalign), 32'd1);
      check("mis_req", 32'(O_mem_req), 32'd0);
      check("mis_stall", 32'(O_stallreq), 32'd0);
      tick();
      clear_ex();
      sample();
      check("mis_pulse_end", 32'(O_misalign), 32'd0);
      check("mis_state", 32'(O_dbg_state), 32'(LSU_IDLE));
      tick();
`else
      // misaligned half issues anyway; bytes past the word are dropped
      load_op("mis_lh", LS_HALF, 1'b0, 32'h0000_3001, 5'd17, 32'hAABB_CCDD, 32'hFFFF_BBCC);
      load_op("mis_lw", LS_WORD, 1'b0, 32'h0000_3002, 5'd18, 32'hAABB_CCDD, 32'h0000_AABB);
`endif

      repeat (2) tick();
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
